// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide: shift-add multiply, restoring divide, MTHI/MTLO.
// Mul/div latency WIDTH+1 edges with busy high meanwhile; start while busy is dropped.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg, r_rneg, r_is_div;
  logic               r_busy, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_idle_start, w_acc_mul, w_acc_div, w_mthi, w_mtlo, w_last;
  logic               w_rs_neg, w_rt_neg, w_div0;
  logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
  logic [WIDTH:0]     w_msum, w_trial, w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_idle_start = (r_state == S_IDLE) && start;
  assign w_acc_mul    = w_idle_start && (op[2:1] == 2'b00);
  assign w_acc_div    = w_idle_start && (op[2:1] == 2'b01);
  assign w_mthi       = w_idle_start && (op == 3'b100);
  assign w_mtlo       = w_idle_start && (op == 3'b101);
  assign w_last       = (r_cnt == LAST);

  assign w_rs_neg = ~op[0] && rs_data[WIDTH-1];
  assign w_rt_neg = ~op[0] && rt_data[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_abs = w_rt_neg ? -rt_data : rt_data;
  assign w_div0   = (rt_data == '0);

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_opb};
  assign w_ge    = ~w_diff[WIDTH];

  assign w_prod_fix = r_neg  ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg  ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc_mul)      w_next = S_MUL;
        else if (w_acc_div) w_next = S_DIV;
      end
      S_MUL:   if (w_last) w_next = S_FIX;
      S_DIV:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_is_div <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_acc_mul) begin
            r_acc    <= {{WIDTH{1'b0}}, w_rt_abs};
            r_opb    <= w_rs_abs;
            r_neg    <= w_rs_neg ^ w_rt_neg;
            r_rneg   <= 1'b0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b1;
          end else if (w_acc_div) begin
            // Zero divisor: raw dividend and no sign fixup yields lo=~0, hi=rs naturally
            r_acc    <= {{WIDTH{1'b0}}, (w_div0 ? rs_data : w_rs_abs)};
            r_opb    <= w_div0 ? '0 : w_rt_abs;
            r_neg    <= ~w_div0 && (w_rs_neg ^ w_rt_neg);
            r_rneg   <= ~w_div0 && w_rs_neg;
            r_is_div <= 1'b1;
            r_busy   <= 1'b1;
          end
          if (w_mthi) r_hi <= rs_data;
          if (w_mtlo) r_lo <= rs_data;
        end
        S_MUL: begin
          r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: result table plus latency/reset/ignore sequences.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[13];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done, tallying cycles where busy was unexpectedly low.
  task automatic wait_done(output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, bb;
    launch(v.op, v.rs, v.rt);
    check({v.name, " busy@E0"}, 64'(busy), 64'd1);
    @(negedge clock);
    rs_data = ~v.rs; rt_data = 32'h5A5A_0001;
    wait_done(lat, bb);
    check({v.name, " latency"}, 64'(lat), 64'd33);
    check({v.name, " busy held"}, 64'(bb), 64'd0);
    check({v.name, " busy@done"}, 64'(busy), 64'd0);
    check({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
    check({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
    @(posedge clock);
    #1;
    check({v.name, " done pulse"}, 64'(done), 64'd0);
    check({v.name, " hold lo"}, 64'(lo), 64'(v.exp_lo));
  endtask

  initial begin
    int lat, bb;
    vec_t v;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5"};
    vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult -1*-1"};
    vecs[3]  = '{3'b000, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, "mult min*2"};
    vecs[4]  = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu 2^32"};
    vecs[5]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[6]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7"};
    vecs[7]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
    vecs[8]  = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div -7/-2"};
    vecs[9]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div ovf"};
    vecs[10] = '{3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu by0"};
    vecs[11] = '{3'b010, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div by0"};
    vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu /1"};

    #12;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // MTHI then MTLO on consecutive edges
    @(negedge clock);
    start = 1'b1; op = 3'b100; rs_data = 32'hAAAA5555;
    @(posedge clock); #1;
    check("mthi hi", 64'(hi), 64'hAAAA5555);
    check("mthi lo untouched", 64'(lo), 64'd0);
    check("mthi busy", 64'(busy), 64'd0);
    @(negedge clock);
    op = 3'b101; rs_data = 32'h0F0F0F0F;
    @(posedge clock); #1;
    check("mtlo lo", 64'(lo), 64'h0F0F0F0F);
    check("mtlo hi kept", 64'(hi), 64'hAAAA5555);
    check("mtlo done", 64'(done), 64'd0);
    start = 1'b0;

    // Reset in the middle of a MULT
    launch(3'b000, 32'h00001234, 32'h00005678);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    v = '{3'b001, 32'd3, 32'd4, 32'd0, 32'd12, "multu 3*4 post-rst"};
    run_vec(v);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // MTLO and operand changes during a busy DIVU are ignored
    @(negedge clock);
    start = 1'b1; op = 3'b101; rs_data = 32'h13579BDF;
    @(posedge clock); #1;
    start = 1'b0;
    check("mtlo idle", 64'(lo), 64'h13579BDF);
    launch(3'b011, 32'h00001000, 32'd3);
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 3'b101; rs_data = 32'hDEADBEEF; rt_data = 32'd0;
    @(posedge clock); #1;
    check("busy mtlo lo", 64'(lo), 64'h13579BDF);
    check("busy mtlo busy", 64'(busy), 64'd1);
    @(negedge clock);
    start = 1'b0; op = 3'b000;
    wait_done(lat, bb);
    check("busy mtlo lat", 64'(lat), 64'd28);
    check("busy mtlo q", 64'(lo), 64'h00000555);
    check("busy mtlo r", 64'(hi), 64'h00000001);

    // Reserved opcodes change nothing
    @(negedge clock);
    start = 1'b1; op = 3'b110; rs_data = 32'h11111111; rt_data = 32'd1;
    @(posedge clock); #1;
    check("op110 busy", 64'(busy), 64'd0);
    @(negedge clock);
    op = 3'b111;
    @(posedge clock); #1;
    check("op111 busy", 64'(busy), 64'd0);
    check("nop hi", 64'(hi), 64'h00000001);
    check("nop lo", 64'(lo), 64'h00000555);
    @(negedge clock);
    start = 1'b0;

    // Held start: second op accepted on the edge ending the done cycle
    @(negedge clock);
    start = 1'b1; op = 3'b001; rs_data = 32'd2; rt_data = 32'd3;
    @(posedge clock); #1;
    wait_done(lat, bb);
    check("b2b first lat", 64'(lat), 64'd33);
    check("b2b first lo", 64'(lo), 64'd6);
    @(negedge clock);
    rs_data = 32'd5; rt_data = 32'd7;
    @(posedge clock); #1;
    check("b2b accepted", 64'(busy), 64'd1);
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, bb);
    check("b2b second lat", 64'(lat), 64'd33);
    check("b2b second lo", 64'(lo), 64'd35);
    check("b2b second hi", 64'(hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It consumes the two register-file read operands (rs, rt) for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and computes results over multiple cycles. It holds results in architectural HI/LO registers, which feed the MFHI/MFLO writeback path back into the register file. Control stalls the pipeline on `busy`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only while idle.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `rs_data`  in  WIDTH  register-file ReadData1 (multiplicand / dividend / MTHI/MTLO source).
- `rt_data`  in  WIDTH  register-file ReadData2 (multiplier / divisor).
- `busy`  out  1  high while a multiply/divide is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a multiply/divide result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - MUL: WIDTH shift-add iterations.
  - DIV: WIDTH restoring-division iterations.
  - FIX: sign correction and HI/LO write.
- Transitions:
  - IDLE -> MUL on start with op 000/001.
  - IDLE -> DIV on start with op 010/011.
  - MUL/DIV -> FIX when the iteration counter reaches WIDTH-1.
  - FIX -> IDLE, always.
- Operand capture on the accepting edge:
  - Signed ops (MULT, DIV) store absolute values plus a result-sign flag and a remainder-sign flag.
  - Unsigned ops store operands as-is.
  - `rs_data`/`rt_data` changes while busy are ignored.
- Multiply: 2·WIDTH-bit unsigned product. FIX negates it (two's complement over 2·WIDTH bits) if the result-sign flag is set. hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - lo = quotient, truncated toward zero; negative iff operand signs differ.
  - hi = remainder, carrying the dividend's sign.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF produces lo = 0x80000000, hi = 0 (arises naturally from the WIDTH-bit wrap).
- Divide by zero, detected at capture, full latency still spent:
  - lo = all ones, hi = original rs_data, for both DIV and DIVU.
  - No sign correction applies.
- MTHI/MTLO in IDLE with start:
  - hi (or lo) <= rs_data on that edge.
  - No busy, no done; the other register is unchanged.
- start while busy: ignored entirely, no queuing. Control must hold the request until `busy` is low.
- start with op 110/111: ignored, no state change.
- HI/LO hold their values until the next FIX write, MTHI/MTLO, or reset. During busy they retain the previous results.

## Timing
- Reset (async, any state, including mid-operation): state IDLE; hi = 0, lo = 0, busy = 0, done = 0; counter and operand registers cleared. An in-flight operation is discarded.
- Multiply/divide accepted at edge E0:
  - busy = 1 from after E0 through the FIX cycle.
  - Iterations occupy edges E1..E(WIDTH).
  - FIX completes at edge E(WIDTH+1): hi/lo updated, busy = 0 and done = 1 for exactly one cycle.
  - Latency is WIDTH+1 edges (33 for WIDTH = 32).
- A new start may be accepted on the same edge that ends the done cycle. Back-to-back throughput is one op per WIDTH+2 edges.
- MTHI/MTLO: zero-latency register write at the accepting edge.
- `done` and `busy` are registered outputs with no combinational path from inputs.

## Test plan
- Reset mid-MULT (reset_n low at E10) -> hi = lo = 0, busy = 0, done = 0 immediately. After release, a new MULTU 3×4 gives lo = 12 at E33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF at E0 -> busy through E32; at E33 hi = 0xFFFFFFFE, lo = 0x00000001, one-cycle done. MULT −3 × 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- DIV −7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 -> lo = 14, hi = 2. DIV 7 / −2 -> lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x1234 after full latency.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F on consecutive edges -> hi/lo update on each edge, busy/done stay 0.
- start with MTLO at E5 during a busy DIV, and rs_data changed mid-operation -> both ignored; final result matches the captured operands; lo is not overwritten by the MTLO.
